// File: rtl/collision_pkg.sv
// collision_pkg: shared types and constants for the collision detector.
//   state_t  - FSM encoding (IDLE/RUN/OVER)
//   *_DEF    - default car/object geometry
//   LIVES_W  - width of the lives counter
//   idx_w()  - channel index width, minimum 1 bit
package collision_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam int CAR_Y_DEF  = 70;
  localparam int CAR_W_DEF  = 20;
  localparam int CAR_H_DEF  = 20;
  localparam int POL_W_DEF  = 20;
  localparam int POL_H_DEF  = 20;
  localparam int COIN_W_DEF = 8;
  localparam int COIN_H_DEF = 8;
  localparam int LIVES_W    = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/collision_detector_if.sv
// collision_detector_if: object/car inputs and hit/lives outputs of the
// collision detector.
//   master - game side: drives EnterEn, car and object channels
//   slave  - detector side: drives CoinEn/PoliceEn/hit_idx/lives/status
interface collision_detector_if
  import collision_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7
);
  localparam int IDX_W = idx_w(NUM_OBJ);

  logic                   EnterEn;
  logic [X_W-1:0]         x_car;
  logic [NUM_OBJ*X_W-1:0] obj_x;
  logic [NUM_OBJ*Y_W-1:0] obj_y;
  logic [NUM_OBJ-1:0]     obj_valid;
  logic [NUM_OBJ-1:0]     obj_police;
  logic                   CoinEn;
  logic                   PoliceEn;
  logic [IDX_W-1:0]       hit_idx;
  logic [LIVES_W-1:0]     lives_left;
  logic                   GameOver;
  logic                   running;

  modport master (
    output EnterEn, x_car, obj_x, obj_y, obj_valid, obj_police,
    input  CoinEn, PoliceEn, hit_idx, lives_left, GameOver, running
  );

  modport slave (
    input  EnterEn, x_car, obj_x, obj_y, obj_valid, obj_police,
    output CoinEn, PoliceEn, hit_idx, lives_left, GameOver, running
  );
endinterface

// File: rtl/overlap_check.sv
// overlap_check: combinational rectangle overlap of one object against the car.
//   x_car  - car left x
//   obj_x  - object left x, obj_y - object top y
//   police - selects police (1) or coin (0) object size
//   hit    - rectangles overlap (touching edges do not count)
// All sums run one bit wider than the widest coordinate so nothing wraps.
module overlap_check
  import collision_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int CAR_Y  = CAR_Y_DEF,
  parameter int CAR_W  = CAR_W_DEF,
  parameter int CAR_H  = CAR_H_DEF,
  parameter int POL_W  = POL_W_DEF,
  parameter int POL_H  = POL_H_DEF,
  parameter int COIN_W = COIN_W_DEF,
  parameter int COIN_H = COIN_H_DEF
) (
  input  logic [X_W-1:0] x_car,
  input  logic [X_W-1:0] obj_x,
  input  logic [Y_W-1:0] obj_y,
  input  logic           police,
  output logic           hit
);
  localparam int W = ((X_W > Y_W) ? X_W : Y_W) + 1;

  logic [W-1:0] cx, ox, oy, ow, oh;

  always_comb begin
    cx  = W'(x_car);
    ox  = W'(obj_x);
    oy  = W'(obj_y);
    ow  = police ? W'(POL_W) : W'(COIN_W);
    oh  = police ? W'(POL_H) : W'(COIN_H);
    hit = (ox < cx + W'(CAR_W)) && (cx < ox + ow) &&
          (oy < W'(CAR_Y + CAR_H)) && (W'(CAR_Y) < oy + oh);
  end
endmodule

// File: rtl/collision_detector.sv
// collision_detector: car vs NUM_OBJ objects, one pulse per contact episode.
//   CLOCK_50 - clock, rising edge
//   KEY[0]   - synchronous active-low reset
//   bus      - collision_detector_if.slave (object inputs, hit/lives outputs)
// Optional macro HIT_COOLDOWN_EN: police immunity for COOLDOWN_CYC cycles
// after every police pulse.
module collision_detector
  import collision_pkg::*;
#(
  parameter int NUM_OBJ      = 4,
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int CAR_Y        = CAR_Y_DEF,
  parameter int CAR_W        = CAR_W_DEF,
  parameter int CAR_H        = CAR_H_DEF,
  parameter int POL_W        = POL_W_DEF,
  parameter int POL_H        = POL_H_DEF,
  parameter int COIN_W       = COIN_W_DEF,
  parameter int COIN_H       = COIN_H_DEF,
  parameter int LIVES        = 3,
  parameter int COOLDOWN_CYC = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic [0:0] KEY,
  collision_detector_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_OBJ);

  state_t             state;
  logic [NUM_OBJ-1:0] ovl, seen, pend, pol_lat, newh, add, gnt;
  logic [IDX_W-1:0]   gidx;
  logic               gany, gpol;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_ch
    overlap_check #(
      .X_W(X_W), .Y_W(Y_W), .CAR_Y(CAR_Y), .CAR_W(CAR_W), .CAR_H(CAR_H),
      .POL_W(POL_W), .POL_H(POL_H), .COIN_W(COIN_W), .COIN_H(COIN_H)
    ) u_ovl (
      .x_car (bus.x_car),
      .obj_x (bus.obj_x[g*X_W +: X_W]),
      .obj_y (bus.obj_y[g*Y_W +: Y_W]),
      .police(bus.obj_police[g]),
      .hit   (ovl[g])
    );
  end

  // Rising edge of (overlap & valid) per channel.
  assign newh = ovl & bus.obj_valid & ~seen;

`ifdef HIT_COOLDOWN_EN
  localparam int CD_W = $clog2(COOLDOWN_CYC + 1);
  logic [CD_W-1:0] cd_cnt;

  // Police contacts during immunity still mark seen, they just never pend.
  assign add = newh & ~(bus.obj_police & {NUM_OBJ{cd_cnt != '0}});

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0] || state != RUN) cd_cnt <= '0;
    else if (gany && gpol)       cd_cnt <= CD_W'(COOLDOWN_CYC);
    else if (cd_cnt != '0)       cd_cnt <= cd_cnt - 1'b1;
  end
`else
  assign add = newh;
`endif

  // Lowest pending channel wins.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    gany = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (pend[i] && !gany) begin
        gnt[i] = 1'b1;
        gidx   = IDX_W'(i);
        gany   = 1'b1;
      end
    end
    gpol = |(gnt & pol_lat);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      state          <= IDLE;
      seen           <= '0;
      pend           <= '0;
      pol_lat        <= '0;
      bus.CoinEn     <= 1'b0;
      bus.PoliceEn   <= 1'b0;
      bus.hit_idx    <= '0;
      bus.lives_left <= LIVES_W'(LIVES);
      bus.GameOver   <= 1'b0;
      bus.running    <= 1'b0;
    end else begin
      bus.CoinEn   <= 1'b0;
      bus.PoliceEn <= 1'b0;
      case (state)
        RUN: begin
          seen    <= ovl & bus.obj_valid;
          pol_lat <= (pol_lat & ~add) | (bus.obj_police & add);
          pend    <= (pend & ~gnt) | add;
          if (gany) begin
            bus.hit_idx <= gidx;
            if (gpol) begin
              bus.PoliceEn <= 1'b1;
              if (bus.lives_left != '0) bus.lives_left <= bus.lives_left - 1'b1;
              if (bus.lives_left == LIVES_W'(1)) begin
                // Last life gone: anything still queued is dropped.
                state        <= OVER;
                pend         <= '0;
                bus.GameOver <= 1'b1;
                bus.running  <= 1'b0;
              end
            end else begin
              bus.CoinEn <= 1'b1;
            end
          end
        end
        IDLE, OVER: begin
          seen <= '0;
          pend <= '0;
          if (bus.EnterEn) begin
            state          <= RUN;
            bus.lives_left <= LIVES_W'(LIVES);
            bus.GameOver   <= 1'b0;
            bus.running    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_collision_detector.sv
module tb_collision_detector;
  localparam int N    = 4;
  localparam int LIV  = 3;
  localparam int COOL = 100;

  logic       clk = 1'b0;
  logic [0:0] key;
  int n_cmp = 0, n_err = 0;

  collision_detector_if #(.NUM_OBJ(N), .X_W(8), .Y_W(7)) bus ();

  collision_detector #(.NUM_OBJ(N), .X_W(8), .Y_W(7), .LIVES(LIV),
                       .COOLDOWN_CYC(COOL)) dut (
    .CLOCK_50(clk), .KEY(key), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: game-level view (mode, lives, contact episodes, queue).
  int m_mode, m_lives, m_idx, m_cd;
  bit m_coin, m_pol;
  bit m_contact[N], m_pend[N], m_ptype[N];

  function automatic bit touching(int i);
    int ox, oy, xc, ow, oh;
    ox = int'(bus.obj_x[i*8 +: 8]);
    oy = int'(bus.obj_y[i*7 +: 7]);
    xc = int'(bus.x_car);
    ow = bus.obj_police[i] ? 20 : 8;
    oh = bus.obj_police[i] ? 20 : 8;
    return bus.obj_valid[i] && ox < xc + 20 && xc < ox + ow && oy < 90 && 70 < oy + oh;
  endfunction

  task automatic model_edge();
    int g = -1;
    bit gp = 0, blocked;
    m_coin = 0; m_pol = 0;
    if (!key[0]) begin
      m_mode = 0; m_lives = LIV; m_idx = 0; m_cd = 0;
      foreach (m_pend[i]) begin m_pend[i] = 0; m_contact[i] = 0; m_ptype[i] = 0; end
      return;
    end
    if (m_mode != 1) begin
      foreach (m_pend[i]) begin m_pend[i] = 0; m_contact[i] = 0; end
      m_cd = 0;
      if (bus.EnterEn) begin m_mode = 1; m_lives = LIV; end
      return;
    end
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) g = i;
    if (g >= 0) begin gp = m_ptype[g]; m_pend[g] = 0; end
    for (int i = 0; i < N; i++) begin
      bit now = touching(i);
`ifdef HIT_COOLDOWN_EN
      blocked = bus.obj_police[i] && m_cd > 0;
`else
      blocked = 0;
`endif
      if (now && !m_contact[i] && !blocked) begin
        m_pend[i] = 1; m_ptype[i] = bus.obj_police[i];
      end
      m_contact[i] = now;
    end
    if (m_cd > 0) m_cd--;
    if (g >= 0) begin
      m_idx = g;
      if (gp) begin
        m_pol = 1; m_cd = COOL;
        if (m_lives == 1) begin
          m_mode = 2;
          foreach (m_pend[i]) m_pend[i] = 0;
        end
        if (m_lives > 0) m_lives--;
      end else m_coin = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_obj(int i, bit v, bit p, int x, int y);
    bus.obj_valid[i]      = v;
    bus.obj_police[i]     = p;
    bus.obj_x[i*8 +: 8]   = 8'(x);
    bus.obj_y[i*7 +: 7]   = 7'(y);
  endtask

  task automatic clear_objs(int cyc);
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0);
    repeat (cyc) tick();
  endtask

  task automatic restart();
    key = 1'b0; tick();
    key = 1'b1; bus.EnterEn = 1'b1; tick();
    bus.EnterEn = 1'b0;
  endtask

  task automatic test_reset();
    key = 1'b0; bus.EnterEn = 1'b0; bus.x_car = 8'd45;
    for (int i = 0; i < N; i++) set_obj(i, 0, 0, 0, 0);
    tick(); tick();
    n_cmp++;
    if ({bus.CoinEn, bus.PoliceEn, bus.hit_idx, bus.lives_left, bus.GameOver, bus.running} !== {1'b0, 1'b0, 2'd0, 3'd3, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state got %b required %b", {bus.CoinEn, bus.PoliceEn, bus.hit_idx, bus.lives_left, bus.GameOver, bus.running}, 9'b00_00_011_00);
    end
    key = 1'b1; bus.EnterEn = 1'b1; tick(); bus.EnterEn = 1'b0;
    n_cmp++;
    if (bus.running !== 1'b1) begin n_err++; $display("FAIL enter_run running=%b required 1", bus.running); end
  endtask

  task automatic test_single_coin();
    int cnt = 0;
    set_obj(0, 1, 0, 40, 70); bus.x_car = 8'd45;
    tick();
    n_cmp++;
    if (bus.CoinEn !== 1'b0) begin n_err++; $display("FAIL coin_latency1 CoinEn=%b required 0", bus.CoinEn); end
    tick();
    n_cmp++;
    if (bus.CoinEn !== 1'b1 || bus.hit_idx !== 2'd0) begin
      n_err++; $display("FAIL coin_pulse CoinEn=%b idx=%0d required 1/0", bus.CoinEn, bus.hit_idx);
    end
    repeat (48) begin tick(); cnt += bus.CoinEn; end
    n_cmp++;
    if (cnt !== 0) begin n_err++; $display("FAIL coin_once extra pulses=%0d required 0", cnt); end
    clear_objs(3);
  endtask

  task automatic test_simultaneous();
    set_obj(1, 1, 1, 60, 70); set_obj(3, 1, 0, 50, 70); bus.x_car = 8'd55;
    tick();
    n_cmp++;
    if (bus.CoinEn | bus.PoliceEn) begin n_err++; $display("FAIL simul_latency got pulse required none"); end
    tick();
    n_cmp++;
    if ({bus.PoliceEn, bus.CoinEn, bus.hit_idx, bus.lives_left} !== {1'b1, 1'b0, 2'd1, 3'd2}) begin
      n_err++; $display("FAIL simul_first pol=%b coin=%b idx=%0d lives=%0d required 1/0/1/2", bus.PoliceEn, bus.CoinEn, bus.hit_idx, bus.lives_left);
    end
    tick();
    n_cmp++;
    if ({bus.PoliceEn, bus.CoinEn, bus.hit_idx, bus.lives_left} !== {1'b0, 1'b1, 2'd3, 3'd2}) begin
      n_err++; $display("FAIL simul_second pol=%b coin=%b idx=%0d lives=%0d required 0/1/3/2", bus.PoliceEn, bus.CoinEn, bus.hit_idx, bus.lives_left);
    end
    clear_objs(3);
  endtask

  task automatic test_lives();
    int cnt = 0;
    restart(); clear_objs(1);
    bus.x_car = 8'd55;
    for (int c = 0; c < 3; c++) begin
      set_obj(1, 1, 1, 60, 70);
      tick(); tick();
      n_cmp++;
      if (bus.PoliceEn !== 1'b1 || bus.lives_left !== 3'(2 - c)) begin
        n_err++; $display("FAIL lives_hit%0d pol=%b lives=%0d required 1/%0d", c, bus.PoliceEn, bus.lives_left, 2 - c);
      end
      set_obj(1, 0, 1, 60, 70); tick(); tick();
    end
    n_cmp++;
    if (bus.GameOver !== 1'b1 || bus.running !== 1'b0) begin
      n_err++; $display("FAIL game_over GameOver=%b running=%b required 1/0", bus.GameOver, bus.running);
    end
    set_obj(1, 1, 1, 60, 70);
    repeat (6) begin tick(); cnt += bus.PoliceEn + bus.CoinEn; end
    n_cmp++;
    if (cnt !== 0) begin n_err++; $display("FAIL over_frozen pulses=%0d required 0", cnt); end
    clear_objs(1);
    bus.EnterEn = 1'b1; tick(); bus.EnterEn = 1'b0;
    n_cmp++;
    if ({bus.running, bus.GameOver, bus.lives_left} !== {1'b1, 1'b0, 3'd3}) begin
      n_err++; $display("FAIL restart running=%b GameOver=%b lives=%0d required 1/0/3", bus.running, bus.GameOver, bus.lives_left);
    end
  endtask

  task automatic test_reentry_edge();
    int c1 = 0, c2 = 0, c3 = 0, c4 = 0, c5 = 0;
    bus.x_car = 8'd45;
    set_obj(2, 1, 0, 40, 70); repeat (5) begin tick(); c1 += bus.CoinEn; end
    set_obj(2, 0, 0, 40, 70); tick(); c2 += bus.CoinEn;
    set_obj(2, 1, 0, 40, 70); repeat (5) begin tick(); c2 += bus.CoinEn; end
    n_cmp++;
    if (c1 !== 1 || c2 !== 1) begin n_err++; $display("FAIL reentry pulses=%0d,%0d required 1,1", c1, c2); end
    clear_objs(2);
    bus.x_car = 8'd48;                       // x_car == obj_x + COIN_W
    set_obj(2, 1, 0, 40, 70); repeat (5) begin tick(); c3 += bus.CoinEn; end
    clear_objs(1);
    bus.x_car = 8'd47;                       // one pixel of overlap
    set_obj(2, 1, 0, 40, 70); repeat (5) begin tick(); c4 += bus.CoinEn; end
    clear_objs(1);
    bus.x_car = 8'd45;                       // obj_x == x_car + CAR_W, and y at CAR_Y+CAR_H
    set_obj(2, 1, 1, 65, 70); set_obj(0, 1, 0, 45, 90);
    repeat (5) begin tick(); c5 += bus.CoinEn + bus.PoliceEn; end
    n_cmp++;
    if (c3 !== 0 || c4 !== 1 || c5 !== 0) begin
      n_err++; $display("FAIL edge_contact pulses=%0d/%0d/%0d required 0/1/0", c3, c4, c5);
    end
    clear_objs(2);
  endtask

  task automatic test_reset_midop();
    int cnt = 0;
    bus.x_car = 8'd45;
    set_obj(0, 1, 0, 40, 70); set_obj(1, 1, 1, 50, 70);
    tick();
    key = 1'b0; tick();
    n_cmp++;
    if ({bus.CoinEn, bus.PoliceEn, bus.hit_idx, bus.lives_left, bus.GameOver, bus.running} !== {1'b0, 1'b0, 2'd0, 3'd3, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_midop got %b required %b", {bus.CoinEn, bus.PoliceEn, bus.hit_idx, bus.lives_left, bus.GameOver, bus.running}, 9'b00_00_011_00);
    end
    key = 1'b1;
    repeat (4) begin tick(); cnt += bus.CoinEn + bus.PoliceEn + bus.running; end
    n_cmp++;
    if (cnt !== 0) begin n_err++; $display("FAIL reset_abort activity=%0d required 0", cnt); end
    clear_objs(1);
  endtask

  task automatic test_random();
    logic [8:0] exp_v, got_v;
    int bad = 0;
    restart();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0)
          set_obj(i, 1'($urandom), 1'($urandom), $urandom_range(20, 100), $urandom_range(45, 100));
      if ($urandom_range(0, 15) == 0) bus.x_car = 8'($urandom_range(20, 90));
      bus.EnterEn = ($urandom_range(0, 19) == 0);
      key = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick();
      exp_v = {m_coin, m_pol, 2'(m_idx), 3'(m_lives), m_mode == 2, m_mode == 1};
      got_v = {bus.CoinEn, bus.PoliceEn, bus.hit_idx, bus.lives_left, bus.GameOver, bus.running};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        if (bad++ < 10) $display("FAIL random_cyc%0d got %b required %b", c, got_v, exp_v);
      end
    end
    key = 1'b1; bus.EnterEn = 1'b0;
    clear_objs(3);
  endtask

`ifdef HIT_COOLDOWN_EN
  task automatic test_cooldown();
    int c1 = 0, c2 = 0, c3 = 0;
    restart(); clear_objs(1);
    bus.x_car = 8'd45;
    set_obj(0, 1, 1, 40, 70);
    repeat (3) begin tick(); c1 += bus.PoliceEn; end
    set_obj(0, 0, 1, 40, 70); repeat (47) tick();
    set_obj(0, 1, 1, 40, 70); repeat (4) begin tick(); c2 += bus.PoliceEn; end
    set_obj(0, 0, 1, 40, 70); repeat (66) tick();
    set_obj(0, 1, 1, 40, 70); repeat (4) begin tick(); c3 += bus.PoliceEn; end
    n_cmp++;
    if (c1 !== 1 || c2 !== 0 || c3 !== 1) begin
      n_err++; $display("FAIL cooldown pulses=%0d/%0d/%0d required 1/0/1", c1, c2, c3);
    end
    clear_objs(2);
  endtask
`endif

  initial begin
    test_reset();
    test_single_coin();
    test_simultaneous();
    test_lives();
    test_reentry_edge();
    test_reset_midop();
`ifdef HIT_COOLDOWN_EN
    test_cooldown();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
